// File: rtl/ldw_pipe_ctrl.sv
// Pipeline sequencing controller: forwarding selects, load-use bubbles, dmem wait freeze.
// Optional PIPE_STALL_CNT_EN builds a 32-bit stall-cycle counter.
module ldw_pipe_ctrl #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [4:0]  drs,
    input  logic [4:0]  drt,
    input  logic        d_use_rs,
    input  logic        d_use_rt,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic [4:0]  ern,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic [4:0]  mrn,
    input  logic        m_memop,
    input  logic        dmem_ready,
    output logic [1:0]  fwda,
    output logic [1:0]  fwdb,
    output logic        wpcir,
    output logic        wde,
    output logic        de_bubble,
    output logic        wem,
    output logic        mw_bubble,
    output logic        mem_err,
    output logic [31:0] stall_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        MWAIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic             mem_err_q, mem_err_d;
    logic             timeout_hit;
    logic             mem_stall;
    logic             load_use;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] r,
        input logic       e_wr,
        input logic       e_ld,
        input logic [4:0] e_rn,
        input logic       m_wr,
        input logic       m_ld,
        input logic [4:0] m_rn
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (e_wr && (e_rn != 5'd0) && (e_rn == r) && !e_ld) begin
            sel = 2'b01;
        end else if (m_wr && (m_rn != 5'd0) && (m_rn == r)) begin
            sel = m_ld ? 2'b11 : 2'b10;
        end
        return sel;
    endfunction

    always_comb begin
        fwda = fwd_sel(drs, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
        fwdb = fwd_sel(drt, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
    end

    assign load_use = ewreg && em2reg && (ern != 5'd0) &&
                      ((d_use_rs && (ern == drs)) ||
                       (d_use_rt && (ern == drt)));

    assign timeout_hit = (state_q == MWAIT) &&
                         (wcnt_q == CNT_W'(TIMEOUT - 1));

    // Gated by clr so the freeze lifts as soon as reset is raised.
    assign mem_stall = m_memop && !dmem_ready && !timeout_hit && !clr;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        mem_err_d = mem_err_q | timeout_hit;
        unique case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d = MWAIT;
                    wcnt_d  = '0;
                end
            end
            MWAIT: begin
                if (mem_stall) begin
                    wcnt_d = wcnt_q + CNT_W'(1);
                end else begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end
            end
            default: begin
                state_d = RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= RUN;
            wcnt_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;

    always_comb begin
        wpcir     = 1'b1;
        wde       = 1'b1;
        de_bubble = 1'b0;
        wem       = 1'b1;
        mw_bubble = 1'b0;
        if (mem_stall) begin
            wpcir     = 1'b0;
            wde       = 1'b0;
            wem       = 1'b0;
            mw_bubble = 1'b1;
        end else if (load_use) begin
            wpcir     = 1'b0;
            de_bubble = 1'b1;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + 32'(mem_stall | load_use);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ldw_pipe_ctrl.sv
// Directed bench for ldw_pipe_ctrl (TIMEOUT=4).
module tb_ldw_pipe_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic [4:0]  drs, drt, ern, mrn;
    logic        d_use_rs, d_use_rt;
    logic        ewreg, em2reg, mwreg, mm2reg;
    logic        m_memop, dmem_ready;
    logic [1:0]  fwda, fwdb;
    logic        wpcir, wde, de_bubble, wem, mw_bubble, mem_err;
    logic [31:0] stall_cnt;
    logic [4:0]  ctrl;

    int total = 0;
    int bad   = 0;

    localparam logic [4:0] NORM = 5'b11010;
    localparam logic [4:0] LU   = 5'b01110;
    localparam logic [4:0] MS   = 5'b00001;

`ifdef PIPE_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    assign ctrl = {wpcir, wde, de_bubble, wem, mw_bubble};

    always #5 clk = ~clk;

    ldw_pipe_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .clr(clr),
        .drs(drs), .drt(drt),
        .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
        .ewreg(ewreg), .em2reg(em2reg), .ern(ern),
        .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn),
        .m_memop(m_memop), .dmem_ready(dmem_ready),
        .fwda(fwda), .fwdb(fwdb),
        .wpcir(wpcir), .wde(wde), .de_bubble(de_bubble),
        .wem(wem), .mw_bubble(mw_bubble),
        .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    task automatic idle_inputs();
        drs = 0; drt = 0; ern = 0; mrn = 0;
        d_use_rs = 0; d_use_rt = 0;
        ewreg = 0; em2reg = 0; mwreg = 0; mm2reg = 0;
        m_memop = 0; dmem_ready = 0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        idle_inputs();
        @(negedge clk);
        total++;
        if (ctrl !== NORM) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=%b", ctrl, NORM);
        end
        total++;
        if (mem_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_err got=%b want=0", mem_err);
        end
        total++;
        if (stall_cnt !== 32'd0) begin
            bad++;
            $display("FAIL reset_cnt got=%0d want=0", stall_cnt);
        end
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic test_forwarding();
        logic [1:0] ea [5];
        logic [1:0] eb [5];
        ea = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
        eb = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            drt = 5'd3;
            unique case (i)
                0: begin ewreg = 1; ern = 5; drs = 5; end
                1: begin mwreg = 1; mrn = 5; drs = 5; end
                2: begin mwreg = 1; mm2reg = 1; mrn = 5; drs = 5; end
                3: begin ewreg = 1; mwreg = 1; drt = 0; end
                default: begin
                    ewreg = 1; ern = 5; mwreg = 1; mrn = 5;
                    drs = 5; drt = 5;
                end
            endcase
            @(negedge clk);
            total++;
            if (fwda !== ea[i]) begin
                bad++;
                $display("FAIL fwda_%0d got=%b want=%b", i, fwda, ea[i]);
            end
            total++;
            if (fwdb !== eb[i]) begin
                bad++;
                $display("FAIL fwdb_%0d got=%b want=%b", i, fwdb, eb[i]);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_load_use();
        idle_inputs();
        ewreg = 1; em2reg = 1; ern = 7; drt = 7; d_use_rt = 1;
        @(negedge clk);
        total++;
        if (ctrl !== LU) begin
            bad++;
            $display("FAIL lu_stall got=%b want=%b", ctrl, LU);
        end
        @(posedge clk); #1;
        ewreg = 0; em2reg = 0; ern = 0;
        @(negedge clk);
        total++;
        if (ctrl !== NORM) begin
            bad++;
            $display("FAIL lu_release got=%b want=%b", ctrl, NORM);
        end
        @(posedge clk); #1;
        ewreg = 1; em2reg = 1; ern = 7; d_use_rt = 0;
        @(negedge clk);
        total++;
        if (ctrl !== NORM) begin
            bad++;
            $display("FAIL lu_nouse got=%b want=%b", ctrl, NORM);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_mem_wait();
        idle_inputs();
        m_memop = 1;
        // Load-use pending too: memory stall must win.
        ewreg = 1; em2reg = 1; ern = 9; drs = 9; d_use_rs = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (ctrl !== MS) begin
                bad++;
                $display("FAIL mw_stall_%0d got=%b want=%b", i, ctrl, MS);
            end
            @(posedge clk); #1;
        end
        dmem_ready = 1;
        @(negedge clk);
        total++;
        if (ctrl !== LU) begin
            bad++;
            $display("FAIL mw_release got=%b want=%b", ctrl, LU);
        end
        @(posedge clk); #1;
        idle_inputs();
        m_memop = 1; dmem_ready = 1;
        @(negedge clk);
        total++;
        if (ctrl !== NORM) begin
            bad++;
            $display("FAIL mw_zero got=%b want=%b", ctrl, NORM);
        end
        total++;
        if (mem_err !== 1'b0) begin
            bad++;
            $display("FAIL mw_err got=%b want=0", mem_err);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_timeout();
        idle_inputs();
        m_memop = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (ctrl !== MS) begin
                bad++;
                $display("FAIL to_stall_%0d got=%b want=%b", i, ctrl, MS);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++;
        if (ctrl !== NORM || mem_err !== 1'b0) begin
            bad++;
            $display("FAIL to_hit got=%b/%b want=%b/0", ctrl, mem_err, NORM);
        end
        @(posedge clk); #1;
        m_memop = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (mem_err !== 1'b1 || ctrl !== NORM) begin
                bad++;
                $display("FAIL to_sticky_%0d got=%b/%b want=1/%b",
                         i, mem_err, ctrl, NORM);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_in_wait();
        idle_inputs();
        m_memop = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (ctrl !== MS || mem_err !== 1'b1) begin
                bad++;
                $display("FAIL rw_wait_%0d got=%b/%b want=%b/1",
                         i, ctrl, mem_err, MS);
            end
            @(posedge clk); #1;
        end
        clr = 1'b1;
        #1;
        total++;
        if (wpcir !== 1'b1 || mem_err !== 1'b0) begin
            bad++;
            $display("FAIL rw_clr got=%b/%b want=1/0", wpcir, mem_err);
        end
        total++;
        if (dut.wcnt_q !== 8'd0) begin
            bad++;
            $display("FAIL rw_wcnt got=%0d want=0", dut.wcnt_q);
        end
        @(posedge clk); #1;
        clr = 1'b0;
        m_memop = 0;
        @(negedge clk);
        total++;
        if (ctrl !== NORM) begin
            bad++;
            $display("FAIL rw_after got=%b want=%b", ctrl, NORM);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall_cnt();
        logic [31:0] exp;
        clr = 1'b1;
        idle_inputs();
        #1;
        clr = 1'b0;
        m_memop = 1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        dmem_ready = 1;
        @(posedge clk); #1;
        idle_inputs();
        ewreg = 1; em2reg = 1; ern = 4; drs = 4; d_use_rs = 1;
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
        exp = CNT_EN ? 32'd4 : 32'd0;
        total++;
        if (stall_cnt !== exp) begin
            bad++;
            $display("FAIL stall_cnt got=%0d want=%0d", stall_cnt, exp);
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_reset_in_wait();
        test_stall_cnt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
